inst_fetch_queue: RTL and testbench

//  Decoupling FIFO between instruction memory and decode. Captures the IM fetch stage output (inst, pc, valid) every cycle.

---
 rtl/inst_fetch_queue_pkg.sv | 15 +
 rtl/inst_fetch_queue_ram.sv | 27 ++
 rtl/inst_fetch_queue.sv | 109 ++++++++++
 tb/tb_inst_fetch_queue.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared pipeline types for the instruction fetch queue.
`default_nettype none

package inst_fetch_queue_pkg;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fq_entry_t;

  localparam logic [31:0] NOP_INST = 32'h0;

endpackage

`default_nettype wire

// File: rtl/inst_fetch_queue_ram.sv
// inst_fetch_queue_ram: DEPTH x fq_entry_t storage, synchronous write, asynchronous read.
`default_nettype none

module inst_fetch_queue_ram
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  fq_entry_t                wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output fq_entry_t                rdata
);

  fq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: show-ahead decoupling FIFO between IM and decode, rev 1.0.
// Optional same-cycle empty-queue bypass enabled by defining IFQ_BYPASS_EN.
`default_nettype none

module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              in_inst,
  input  logic [31:0]              in_pc,
  input  logic                     in_valid,
  input  logic                     flush,
  output logic                     stall_out,
  output logic [31:0]              out_inst,
  output logic [31:0]              out_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL = CW'(DEPTH - AFULL_MARGIN);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  fq_entry_t     head;
  fq_entry_t     wdata;
  logic          q_valid;
  logic          bypass;
  logic          pass_through;
  logic          deq;
  logic          enq;
  logic          drop;

  assign q_valid = (count != '0);

`ifdef IFQ_BYPASS_EN
  assign bypass = !q_valid && in_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word taken by decode in the same cycle never touches storage.
  assign pass_through = bypass && out_ready;
  assign deq          = q_valid && out_ready && !flush;
  assign enq          = in_valid && !flush && !pass_through && (count != FULL || deq);
  assign drop         = in_valid && !flush && (count == FULL) && !deq;

  assign out_valid = q_valid || bypass;
  assign stall_out = (count >= AFULL);
  assign wdata     = '{inst: in_inst, pc: in_pc};

  always_comb begin
    out_inst = NOP_INST;
    out_pc   = 32'h0;
    if (q_valid) begin
      out_inst = head.inst;
      out_pc   = head.pc;
    end else if (bypass) begin
      out_inst = in_inst;
      out_pc   = in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  inst_fetch_queue_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (enq),
    .waddr(wr_ptr),
    .wdata(wdata),
    .raddr(rd_ptr),
    .rdata(head)
  );

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: table vectors, corner sequences and a random queue-model check.
`default_nettype none

module tb_inst_fetch_queue;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   in_inst, in_pc, out_inst, out_pc;
  logic          in_valid, flush, stall_out, out_valid, out_ready, overflow;
  logic [CW-1:0] count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH), .AFULL_MARGIN(2)) dut (
    .clk(clk), .rst(rst), .in_inst(in_inst), .in_pc(in_pc), .in_valid(in_valid),
    .flush(flush), .stall_out(stall_out), .out_inst(out_inst), .out_pc(out_pc),
    .out_valid(out_valid), .out_ready(out_ready), .count(count), .overflow(overflow)
  );

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        r;
    logic        f;
    int          cnt;
    logic [31:0] hpc;
    logic        ovf;
  } vec_t;

  vec_t vt[$];

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0013;
  endfunction

  function automatic void add(input logic v, input logic [31:0] pc, input logic r,
                              input logic f, input int cnt, input logic [31:0] hpc,
                              input logic ovf);
    vec_t e;
    e.v = v; e.pc = pc; e.r = r; e.f = f; e.cnt = cnt; e.hpc = hpc; e.ovf = ovf;
    vt.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_pc = 32'h0; in_inst = 32'h0;
  endtask

  // Expected state after the edge, observed with inputs idle so the bypass path is quiet.
  task automatic check_state(input string tag, input int cnt, input logic [31:0] hpc,
                             input logic ovf);
    logic v;
    v = (cnt != 0);
    chk({tag, " count"},     32'(count),     32'(cnt));
    chk({tag, " out_valid"}, 32'(out_valid), 32'(v));
    chk({tag, " out_pc"},    out_pc,         v ? hpc : 32'h0);
    chk({tag, " out_inst"},  out_inst,       v ? inst_of(hpc) : 32'h0);
    chk({tag, " stall_out"}, 32'(stall_out), 32'(cnt >= DEPTH - 2));
    chk({tag, " overflow"},  32'(overflow),  32'(ovf));
  endtask

  task automatic apply(input vec_t e, input int idx);
    @(negedge clk);
    in_valid = e.v; in_pc = e.pc; in_inst = inst_of(e.pc); out_ready = e.r; flush = e.f;
    @(posedge clk);
    #1 idle();
    #1 check_state($sformatf("vec%0d", idx), e.cnt, e.hpc, e.ovf);
  endtask

  // Reference model state for the random phase.
  logic [63:0] mq[$];
  logic        movf;

  task automatic rand_cycle(input int cyc);
    logic        v, r, f, pop, byp, byp_take;
    logic [31:0] pc, ins, ev_pc, ev_inst;
    logic        ev_valid;
    string       tag;
    v   = ($urandom_range(0, 99) < 65);
    r   = ($urandom_range(0, 99) < ((cyc / 64) % 2 == 0 ? 30 : 70));
    f   = ($urandom_range(0, 99) < 3);
    pc  = $urandom;
    ins = $urandom;
    @(negedge clk);
    in_valid = v; in_pc = pc; in_inst = ins; out_ready = r; flush = f;
    #1;
`ifdef IFQ_BYPASS_EN
    byp = (mq.size() == 0) && v && !f;
`else
    byp = 1'b0;
`endif
    ev_valid = (mq.size() != 0) || byp;
    ev_pc    = (mq.size() != 0) ? mq[0][31:0]  : (byp ? pc  : 32'h0);
    ev_inst  = (mq.size() != 0) ? mq[0][63:32] : (byp ? ins : 32'h0);
    tag = $sformatf("rnd%0d", cyc);
    chk({tag, " count"},     32'(count),     32'(mq.size()));
    chk({tag, " out_valid"}, 32'(out_valid), 32'(ev_valid));
    chk({tag, " out_pc"},    out_pc,         ev_pc);
    chk({tag, " out_inst"},  out_inst,       ev_inst);
    chk({tag, " stall_out"}, 32'(stall_out), 32'(mq.size() >= DEPTH - 2));
    chk({tag, " overflow"},  32'(overflow),  32'(movf));
    if (f) begin
      mq.delete();
    end else begin
      pop      = (mq.size() != 0) && r;
      byp_take = byp && r;
      if (v && !byp_take && mq.size() == DEPTH && !pop) movf = 1'b1;
      if (pop) void'(mq.pop_front());
      if (v && !byp_take && mq.size() < DEPTH) mq.push_back({ins, pc});
    end
  endtask

  initial begin
    logic [31:0] drain_q [8];
    idle();
    rst = 1'b0;
    #12;
    check_state("reset", 0, 32'h0, 1'b0);
    @(negedge clk) rst = 1'b1;

    // In-order delivery with back-pressure, then drain.
    add(1, 32'h00, 0, 0, 1, 32'h00, 0);
    add(1, 32'h04, 0, 0, 2, 32'h00, 0);
    add(1, 32'h08, 0, 0, 3, 32'h00, 0);
    add(0, 32'h00, 1, 0, 2, 32'h04, 0);
    add(0, 32'h00, 1, 0, 1, 32'h08, 0);
    add(0, 32'h00, 1, 0, 0, 32'h00, 0);
    // Fill to almost-full and full, then a dropped ninth push.
    for (int i = 0; i < 8; i++) add(1, 32'h100 + 32'(4 * i), 0, 0, i + 1, 32'h100, 0);
    add(1, 32'h120, 0, 0, 8, 32'h100, 1);
    // Full with a simultaneous dequeue still accepts.
    add(1, 32'h124, 1, 0, 8, 32'h104, 1);
    add(1, 32'h128, 1, 0, 8, 32'h108, 1);
    drain_q = '{32'h10c, 32'h110, 32'h114, 32'h118, 32'h11c, 32'h124, 32'h128, 32'h0};
    for (int i = 0; i < 8; i++) add(0, 32'h0, 1, 0, 7 - i, drain_q[i], 1);
    // Flush overrides a simultaneous push and pop.
    for (int i = 0; i < 5; i++) add(1, 32'h200 + 32'(4 * i), 0, 0, i + 1, 32'h200, 1);
    add(1, 32'h214, 1, 1, 0, 32'h0, 1);
    add(1, 32'h218, 0, 0, 1, 32'h218, 1);
    add(0, 32'h000, 1, 0, 0, 32'h0, 1);

    for (int i = 0; i < vt.size(); i++) apply(vt[i], i);

    // Asynchronous reset between clock edges.
    @(negedge clk);
    in_valid = 1'b1; in_pc = 32'h300; in_inst = inst_of(32'h300);
    @(negedge clk);
    in_pc = 32'h304; in_inst = inst_of(32'h304);
    @(negedge clk);
    idle();
    #2 rst = 1'b0;
    #1 check_state("async_rst", 0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1; in_pc = 32'h40; in_inst = inst_of(32'h40);
    @(posedge clk);
    #1 idle();
    #1 check_state("post_rst", 1, 32'h40, 1'b0);
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 idle();
    #1 check_state("post_rst_pop", 0, 32'h0, 1'b0);

    // Empty-queue latency: same cycle with bypass, one cycle later without.
    @(negedge clk);
    in_valid = 1'b1; in_pc = 32'h10; in_inst = inst_of(32'h10); out_ready = 1'b1;
    #1;
`ifdef IFQ_BYPASS_EN
    chk("byp same-cycle out_valid", 32'(out_valid), 32'h1);
    chk("byp same-cycle out_pc", out_pc, 32'h10);
    @(posedge clk);
    #1 idle();
    #1 check_state("byp after", 0, 32'h0, 1'b0);
`else
    chk("nobyp same-cycle out_valid", 32'(out_valid), 32'h0);
    chk("nobyp same-cycle out_pc", out_pc, 32'h0);
    @(posedge clk);
    #1 idle();
    #1 check_state("nobyp after", 1, 32'h10, 1'b0);
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 idle();
    #1 check_state("nobyp pop", 0, 32'h0, 1'b0);
`endif

    // Random traffic against the queue model.
    @(negedge clk) rst = 1'b0;
    mq.delete();
    movf = 1'b0;
    @(negedge clk) rst = 1'b1;
    for (int c = 0; c < 600; c++) rand_cycle(c);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
